// File: rtl/tetris_pkg.sv
// Shared display types for the Tetris core and the LED matrix scanner.
// A colour code is 3 bits; color_to_rgb_n maps a code to active-low {r_n,g_n,b_n}.
package tetris_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 3;

  typedef enum logic [2:0] {
    C_OFF = 3'd0,
    C_R   = 3'd1,
    C_B   = 3'd2,
    C_RGB = 3'd3,
    C_RG  = 3'd4,
    C_RB  = 3'd5,
    C_GB  = 3'd6,
    C_G   = 3'd7
  } color_t;

  typedef color_t [ROWS-1:0][COLS-1:0] frame_t;

  function automatic logic [2:0] color_to_rgb_n(input color_t c);
    logic [2:0] lit;
    case (c)
      C_OFF:   lit = 3'b000;
      C_R:     lit = 3'b100;
      C_B:     lit = 3'b001;
      C_RGB:   lit = 3'b111;
      C_RG:    lit = 3'b110;
      C_RB:    lit = 3'b101;
      C_GB:    lit = 3'b011;
      C_G:     lit = 3'b010;
      default: lit = 3'b000;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/led_row_decode.sv
// Combinational decode of one row of colour codes into active-low R/G/B column vectors.
// Zero latency; no flow control. Vector index equals column number.
module led_row_decode #(
  parameter int COLS = 8
) (
  input  logic [COLS*3-1:0] i_row,
  output logic [0:COLS-1]   o_r_n,
  output logic [0:COLS-1]   o_g_n,
  output logic [0:COLS-1]   o_b_n
);
  import tetris_pkg::*;

  always_comb begin
    o_r_n = '1;
    o_g_n = '1;
    o_b_n = '1;
    for (int c = 0; c < COLS; c++) begin
      {o_r_n[c], o_g_n[c], o_b_n[c]} = color_to_rgb_n(color_t'(i_row[c*CW +: CW]));
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 RGB row scanner; frames swap only at the row 7->0 wrap; outputs registered.
// frame_ready drops the cycle after capture and returns the cycle after the swapping wrap. Optional LED_SCAN_PWM_EN adds brightness PWM.
module led_matrix_scan #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CW    = 3,
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  input  logic                    frame_valid,
  input  logic [ROWS*COLS*CW-1:0] frame_data,
  output logic                    frame_ready,
  output logic                    frame_done,
  output logic [0:COLS-1]         DATA_R,
  output logic [0:COLS-1]         DATA_G,
  output logic [0:COLS-1]         DATA_B,
  output logic [2:0]              S,
  output logic                    En
`ifdef LED_SCAN_PWM_EN
  ,
  input  logic [1:0]              brightness
`endif
);
  import tetris_pkg::*;

  localparam int            FW         = ROWS * COLS * CW;
  localparam int            RW         = COLS * CW;
  localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [2:0]    LAST_ROW   = 3'(ROWS - 1);

  logic [FW-1:0]   r_front;
  logic [FW-1:0]   r_back;
  logic            r_pending;
  logic            r_ready;
  logic            r_done;
  logic            r_en;
  logic [DW-1:0]   r_dwell;
  logic [2:0]      r_s;
  logic [0:COLS-1] r_row_r;
  logic [0:COLS-1] r_row_g;
  logic [0:COLS-1] r_row_b;

  logic            w_adv;
  logic            w_wrap;
  logic            w_swap;
  logic            w_cap;
  logic            w_en_next;
  logic [2:0]      w_s_next;
  logic [FW-1:0]   w_src;
  logic [RW-1:0]   w_row;
  logic [0:COLS-1] w_dec_r;
  logic [0:COLS-1] w_dec_g;
  logic [0:COLS-1] w_dec_b;
  logic [0:COLS-1] w_row_next_r;
  logic [0:COLS-1] w_row_next_g;
  logic [0:COLS-1] w_row_next_b;

  assign w_adv     = scan_en && (r_dwell == DWELL_LAST);
  assign w_wrap    = w_adv && (r_s == LAST_ROW);
  // Capture needs !pending and swap needs pending, so the two never coincide.
  assign w_swap    = w_wrap && r_pending;
  assign w_cap     = frame_valid && r_ready;
  assign w_en_next = r_en || w_swap;
  assign w_s_next  = (r_s == LAST_ROW) ? 3'd0 : r_s + 3'd1;

  // Decode the upcoming row from whichever buffer is front after this edge.
  assign w_src = w_swap ? r_back : r_front;
  assign w_row = w_src[int'(w_s_next) * RW +: RW];

  led_row_decode #(
    .COLS (COLS)
  ) u_decode (
    .i_row (w_row),
    .o_r_n (w_dec_r),
    .o_g_n (w_dec_g),
    .o_b_n (w_dec_b)
  );

  assign w_row_next_r = w_adv ? (w_en_next ? w_dec_r : '1) : r_row_r;
  assign w_row_next_g = w_adv ? (w_en_next ? w_dec_g : '1) : r_row_g;
  assign w_row_next_b = w_adv ? (w_en_next ? w_dec_b : '1) : r_row_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front   <= '0;
      r_back    <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_en      <= 1'b0;
      r_dwell   <= '0;
      r_s       <= 3'd0;
      r_row_r   <= '1;
      r_row_g   <= '1;
      r_row_b   <= '1;
    end else begin
      r_done <= w_wrap;
      if (w_cap) begin
        r_back    <= frame_data;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end else if (w_swap) begin
        r_front   <= r_back;
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
        r_en      <= 1'b1;
      end
      if (scan_en) begin
        r_dwell <= w_adv ? '0 : r_dwell + 1'b1;
      end
      if (w_adv) begin
        r_s <= w_s_next;
      end
      r_row_r <= w_row_next_r;
      r_row_g <= w_row_next_g;
      r_row_b <= w_row_next_b;
    end
  end

`ifdef LED_SCAN_PWM_EN
  logic [1:0]      r_sub;
  logic [1:0]      r_bq;
  logic [0:COLS-1] r_out_r;
  logic [0:COLS-1] r_out_g;
  logic [0:COLS-1] r_out_b;
  logic [1:0]      w_sub_next;
  logic [1:0]      w_bq_next;
  logic            w_dark;

  assign w_sub_next = r_sub + 2'd1;
  assign w_bq_next  = w_adv ? brightness : r_bq;
  // Blanking is judged against the values the registers will hold after this edge.
  assign w_dark     = w_sub_next > w_bq_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub   <= 2'd0;
      r_bq    <= 2'd0;
      r_out_r <= '1;
      r_out_g <= '1;
      r_out_b <= '1;
    end else begin
      r_sub   <= w_sub_next;
      r_bq    <= w_bq_next;
      r_out_r <= w_row_next_r | {COLS{w_dark}};
      r_out_g <= w_row_next_g | {COLS{w_dark}};
      r_out_b <= w_row_next_b | {COLS{w_dark}};
    end
  end

  assign DATA_R = r_out_r;
  assign DATA_G = r_out_g;
  assign DATA_B = r_out_b;
`else
  assign DATA_R = r_row_r;
  assign DATA_G = r_row_g;
  assign DATA_B = r_row_b;
`endif

  assign frame_ready = r_ready;
  assign frame_done  = r_done;
  assign S           = r_s;
  assign En          = r_en;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: directed scenarios plus random traffic against a frame-level model.
module tb_led_matrix_scan;
  localparam int DWELL = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan_en;
  logic         frame_valid;
  logic [191:0] frame_data;
  logic         frame_ready;
  logic         frame_done;
  logic [0:7]   DATA_R;
  logic [0:7]   DATA_G;
  logic [0:7]   DATA_B;
  logic [2:0]   S;
  logic         En;
`ifdef LED_SCAN_PWM_EN
  logic [1:0]   brightness = 2'd3;
`endif

  always #5 clk = ~clk;

  led_matrix_scan #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .DATA_R      (DATA_R),
    .DATA_G      (DATA_G),
    .DATA_B      (DATA_B),
    .S           (S),
    .En          (En)
`ifdef LED_SCAN_PWM_EN
    ,
    .brightness  (brightness)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Lit colours per code as {R,G,B}, straight from the colour table.
  int lit_tab [8] = '{0, 4, 1, 7, 6, 5, 3, 2};

  int   m_front [8][8];
  int   m_back  [8][8];
  bit   m_pending;
  bit   m_en;
  bit   m_done;
  int   m_strobes;
  int   exp_s;
  logic [0:7] exp_r, exp_g, exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_outputs();
    int l;
    exp_s = (m_strobes / DWELL) % 8;
    for (int c = 0; c < 8; c++) begin
      l = m_en ? lit_tab[m_front[exp_s][c]] : 0;
      exp_r[c] = ~l[2];
      exp_g[c] = ~l[1];
      exp_b[c] = ~l[0];
    end
  endtask

  // Applied at every rising edge with the inputs the DUT sampled there.
  task automatic model_step();
    bit cap;
    bit adv;
    if (rst) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) m_front[r][c] = 0;
      m_pending = 0;
      m_en      = 0;
      m_done    = 0;
      m_strobes = 0;
    end else begin
      cap = frame_valid && !m_pending;
      if (scan_en) m_strobes++;
      adv    = scan_en && ((m_strobes % DWELL) == 0);
      m_done = adv && (((m_strobes / DWELL) % 8) == 0);
      if (m_done && m_pending) begin
        m_front   = m_back;
        m_pending = 0;
        m_en      = 1;
      end
      if (cap) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) m_back[r][c] = int'(frame_data[(r*8+c)*3 +: 3]);
        m_pending = 1;
      end
    end
    model_outputs();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("S",           32'(S),           32'(exp_s));
      check("En",          32'(En),          32'(m_en));
      check("frame_ready", 32'(frame_ready), 32'(!m_pending));
      check("frame_done",  32'(frame_done),  32'(m_done));
      check("DATA_R",      32'(DATA_R),      32'(exp_r));
      check("DATA_G",      32'(DATA_G),      32'(exp_g));
      check("DATA_B",      32'(DATA_B),      32'(exp_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [191:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      scan_en = 1'b1;
      tick();
    end
    scan_en = 1'b0;
  endtask

  task automatic goto_row(input int target);
    int budget;
    budget  = 0;
    scan_en = 1'b1;
    while (exp_s != target && budget < 40) begin
      tick();
      budget++;
    end
    scan_en = 1'b0;
    if (budget >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto_row timeout: row %0d, required %0d", exp_s, target);
    end
  endtask

  initial begin
    logic [191:0] f;
    int done_cnt;

    rst = 1'b1; scan_en = 1'b1; frame_valid = 1'b1; frame_data = rand_frame();
    tick();
    chk_on  = 1'b1;
    scan_en = 1'b0;
    tick();
    check("rst S", 32'(S), 0);
    check("rst DATA_R", 32'(DATA_R), 32'hFF);
    check("rst DATA_G", 32'(DATA_G), 32'hFF);
    check("rst DATA_B", 32'(DATA_B), 32'hFF);
    check("rst frame_ready", 32'(frame_ready), 1);
    check("rst En", 32'(En), 0);
    check("rst frame_done", 32'(frame_done), 0);
    rst = 1'b0; frame_valid = 1'b0;

    // Two lit cells, then a full scan to reach the first wrap.
    f = '0;
    f[(0*8+0)*3 +: 3] = 3'd1;
    f[(2*8+5)*3 +: 3] = 3'd3;
    frame_valid = 1'b1; frame_data = f;
    tick();
    frame_valid = 1'b0; frame_data = rand_frame();
    check("cap frame_ready", 32'(frame_ready), 0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      scan_en = 1'b1;
      tick();
      if (frame_done) done_cnt++;
    end
    scan_en = 1'b0;
    check("done count", 32'(done_cnt), 1);
    check("wrap S", 32'(S), 0);
    check("wrap En", 32'(En), 1);
    check("row0 DATA_R", 32'(DATA_R), 32'b0111_1111);
    check("row0 DATA_G", 32'(DATA_G), 32'hFF);
    check("row0 DATA_B", 32'(DATA_B), 32'hFF);
    strobe(2);
    check("row2 DATA_R", 32'(DATA_R), 32'b1111_1011);
    check("row2 DATA_G", 32'(DATA_G), 32'b1111_1011);
    check("row2 DATA_B", 32'(DATA_B), 32'b1111_1011);

    // Pending frame: held valid is refused until the wrap frees the buffer.
    frame_valid = 1'b1; frame_data = rand_frame();
    tick();
    frame_data = rand_frame();
    repeat (3) tick();
    check("held frame_ready", 32'(frame_ready), 0);
    goto_row(7);
    check("pre-wrap frame_ready", 32'(frame_ready), 0);
    scan_en = 1'b1;
    tick();
    scan_en = 1'b0;
    check("post-wrap frame_ready", 32'(frame_ready), 1);
    check("post-wrap frame_done", 32'(frame_done), 1);
    tick();
    frame_valid = 1'b0;
    check("recap frame_ready", 32'(frame_ready), 0);
    goto_row(7);
    strobe(1);

    // Capture on the same edge as a row-7 advance: no swap at that wrap.
    goto_row(7);
    frame_valid = 1'b1; frame_data = rand_frame(); scan_en = 1'b1;
    tick();
    frame_valid = 1'b0; scan_en = 1'b0;
    check("cap@wrap S", 32'(S), 0);
    check("cap@wrap frame_done", 32'(frame_done), 1);
    check("cap@wrap frame_ready", 32'(frame_ready), 0);
    strobe(8);
    check("next wrap frame_ready", 32'(frame_ready), 1);

    // Reset mid-scan discards the pending frame.
    frame_valid = 1'b1; frame_data = rand_frame();
    tick();
    frame_valid = 1'b0;
    goto_row(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst S", 32'(S), 0);
    check("mid rst En", 32'(En), 0);
    check("mid rst DATA_R", 32'(DATA_R), 32'hFF);
    check("mid rst frame_ready", 32'(frame_ready), 1);
    strobe(16);
    check("discarded En", 32'(En), 0);
    check("discarded DATA_G", 32'(DATA_G), 32'hFF);

    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 399) == 0);
      scan_en     = ($urandom_range(0, 2) == 0);
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_data  = rand_frame();
      tick();
    end
    rst = 1'b0; scan_en = 1'b0; frame_valid = 1'b0;
    repeat (3) tick();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
